// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring divider sharing one accumulator.
// Latency XLEN+1 edges for iterative ops, 1 edge for divide-by-zero/overflow; start is only sampled in IDLE.
module rv32m_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_sel;
    logic             neg_a;
    logic             neg_b;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  opnd;

    // Request decode, only meaningful in IDLE
    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            in_sign_a;
    logic            in_sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        is_div    = funct3[2];
        a_signed  = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed  = is_div ? ~funct3[0] : ~funct3[1];
        in_sign_a = a_signed & op_a[XLEN-1];
        in_sign_b = b_signed & op_b[XLEN-1];
        mag_a     = in_sign_a ? -op_a : op_a;
        mag_b     = in_sign_b ? -op_b : op_b;
        div_zero  = (op_b == '0);
        div_ovf   = is_div && !funct3[0] && (op_a == MIN_INT) && (op_b == '1);
        if (div_zero) begin
            fast_res = funct3[1] ? op_a : '1;
        end else begin
            fast_res = funct3[1] ? '0 : op_a;
        end
    end

    // Multiply step: acc_lo holds the multiplier and fills with product low bits as it shifts out
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi;
    logic [XLEN-1:0] mul_lo;

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        mul_hi  = mul_sum[XLEN:1];
        mul_lo  = {mul_sum[0], acc_lo[XLEN-1:1]};
    end

    // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_hi;
    logic [XLEN-1:0] div_lo;

    always_comb begin
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_hi    = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_lo    = {acc_lo[XLEN-2:0], div_ge};
    end

    // Sign fix-up applied to the values produced by the final iteration
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   div_res;

    always_comb begin
        prod     = {mul_hi, mul_lo};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        mul_res  = (op_sel[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        quo_fix  = (neg_a ^ neg_b) ? -div_lo : div_lo;
        rem_fix  = neg_a ? -div_hi : div_hi;
        div_res  = op_sel[1] ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_sel <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_sel <= funct3;
                        neg_a  <= in_sign_a;
                        neg_b  <= in_sign_b;
                        if (!is_div) begin
                            state  <= ST_MUL;
                            cnt    <= CNT_INIT;
                            acc_hi <= '0;
                            acc_lo <= mag_b;
                            opnd   <= mag_a;
                        end else if (div_zero || div_ovf) begin
                            state  <= ST_FIN;
                            result <= fast_res;
                        end else begin
                            state  <= ST_DIV;
                            cnt    <= CNT_INIT;
                            acc_hi <= '0;
                            acc_lo <= mag_a;
                            opnd   <= mag_b;
                        end
                    end
                end
                ST_MUL: begin
                    acc_hi <= mul_hi;
                    acc_lo <= mul_lo;
                    cnt    <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state  <= ST_FIN;
                        result <= mul_res;
                    end
                end
                ST_DIV: begin
                    acc_hi <= div_hi;
                    acc_lo <= div_lo;
                    cnt    <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state  <= ST_FIN;
                        result <= div_res;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_MUL) || (state == ST_DIV);
    assign done = (state == ST_FIN);

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Directed bench for rv32m_muldiv_unit: expected results queued at issue time, compared when done pulses.
module tb_rv32m_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    rv32m_muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a request while in IDLE; returns at the sample point just after the accepting edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom_range(0, 7));
    endtask

    // Called at the sample after the accepting edge; returns at the IDLE cycle following done.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        int          lat    = 1;
        int          busy_n = 0;
        logic [31:0] exp;
        busy_n += int'(busy);
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            busy_n += int'(busy);
        end
        check({tag, " done"}, 32'(done), 32'd1);
        if (done && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, " result"}, result, exp);
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(exp_busy));
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   n;
        logic seen;

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        op_a   = '0;
        op_b   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        // Abort a MUL in flight with reset
        start  = 1'b1;
        funct3 = 3'b000;
        op_a   = 32'd7;
        op_b   = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid-mul busy", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort result", result, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= done;
        end
        check("abort no done", 32'(seen), 32'd0);

        issue(3'b000, 32'd7, 32'd6, 32'd42);
        wait_done("MUL 7*6", 33, 32);
        issue(3'b000, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD);
        wait_done("MUL -1*3", 33, 32);
        issue(3'b011, 32'hFFFFFFFF, 32'h00000003, 32'h00000002);
        wait_done("MULHU", 33, 32);
        issue(3'b001, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF);
        wait_done("MULH", 33, 32);
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        wait_done("MULHSU", 33, 32);
        issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        wait_done("MULHU max", 33, 32);

        issue(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        wait_done("DIV -7/2", 33, 32);
        issue(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        wait_done("REM -7%2", 33, 32);
        issue(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC);
        wait_done("DIVU", 33, 32);
        issue(3'b111, 32'hFFFFFFF9, 32'd2, 32'h00000001);
        wait_done("REMU", 33, 32);

        issue(3'b100, 32'h12345678, 32'd0, 32'hFFFFFFFF);
        wait_done("DIV by 0", 1, 0);
        issue(3'b101, 32'h12345678, 32'd0, 32'hFFFFFFFF);
        wait_done("DIVU by 0", 1, 0);
        issue(3'b111, 32'h12345678, 32'd0, 32'h12345678);
        wait_done("REMU by 0", 1, 0);
        issue(3'b110, 32'h12345678, 32'd0, 32'h12345678);
        wait_done("REM by 0", 1, 0);
        issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        wait_done("DIV ovf", 1, 0);
        issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        wait_done("REM ovf", 1, 0);
        issue(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        wait_done("DIVU no ovf", 33, 32);

        // start held high with changing operands throughout a DIV
        start  = 1'b1;
        funct3 = 3'b100;
        op_a   = 32'd100;
        op_b   = 32'd7;
        exp_q.push_back(32'd14);
        @(posedge clk);
        #1;
        n = 1;
        while (!done && n < 200) begin
            funct3 = 3'($urandom_range(0, 7));
            op_a   = $urandom;
            op_b   = $urandom;
            @(posedge clk);
            #1;
            n++;
        end
        check("hold done", 32'(done), 32'd1);
        check("hold latency", 32'(n), 32'd33);
        if (done && exp_q.size() > 0) check("hold result", result, exp_q.pop_front());
        funct3 = 3'b110;
        op_a   = 32'hFFFFFF9C;
        op_b   = 32'd7;
        exp_q.push_back(32'hFFFFFFFE);
        @(posedge clk);
        #1;
        check("idle after fin busy", 32'(busy), 32'd0);
        check("idle after fin done", 32'(done), 32'd0);
        check("idle result held", result, 32'd14);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b accepted", 32'(busy), 32'd1);
        wait_done("b2b REM -100%7", 33, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
